// File: rtl/ramsparb_pkg.sv
// ramsparb_pkg: shared controller state encoding and port indices.
// Rev 1.0
`default_nettype none

package ramsparb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ramsparb_mem.sv
// ramsparb_mem: single-port synchronous RAM, registered read, no reset.
// Rev 1.0
`default_nettype none

module ramsparb_mem
  import ramsparb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // dout holds its previous value on write cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ramsparb.sv
// ramsparb: two-port round-robin arbiter/sequencer in front of a private
// single-port RAM, with optional zero-fill after reset. Rev 1.0
`default_nettype none

module ramsparb
  import ramsparb_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int INIT = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ready
);

  localparam state_e RST_STATE = (INIT != 0) ? ST_INIT : ST_RUN;

  state_e        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= RST_STATE;
      cnt      <= '0;
      last     <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = a_addr;
    mem_din   = a_din;
    case (state)
      ST_INIT: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_din  = '0;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Grants are held low while reset is asserted, even with INIT=0.
        if (nreset) begin
          a_gnt = a_req & (~b_req | (last == PORT_B));
          b_gnt = b_req & (~a_req | (last == PORT_A));
        end
        if (a_gnt) begin
          mem_en   = 1'b1;
          mem_we   = a_we;
          last_nxt = PORT_A;
        end else if (b_gnt) begin
          mem_en   = 1'b1;
          mem_we   = b_we;
          mem_addr = b_addr;
          mem_din  = b_din;
          last_nxt = PORT_B;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  assign ready = (state == ST_RUN);
  assign rdata = (a_rvalid | b_rvalid) ? mem_dout : '0;

  ramsparb_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

endmodule

`default_nettype wire

// File: tb/tb_ramsparb.sv
// tb_ramsparb: table-driven arbitration vectors plus a read-data scoreboard.
// Rev 1.0
`default_nettype none

module tb_ramsparb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          nreset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ready;
  logic [DW-1:0] rdata;
  logic          a_gnt2, b_gnt2, a_rvalid2, b_rvalid2, ready2;
  logic [DW-1:0] rdata2;

  always #5 clk = ~clk;

  ramsparb #(.DW(DW), .AW(AW), .INIT(1)) dut (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ready(ready)
  );

  ramsparb #(.DW(DW), .AW(AW), .INIT(0)) dut_noinit (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2),
    .rdata(rdata2), .ready(ready2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        resp_t e;
        e = exp_q.pop_front();
        chk("rvalid_a", {31'd0, a_rvalid}, {31'd0, e.port == 1'b0});
        chk("rvalid_b", {31'd0, b_rvalid}, {31'd0, e.port == 1'b1});
        chk("rdata", {16'd0, rdata}, {16'd0, e.data});
      end else begin
        chk("idle_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        chk("idle_rdata", {16'd0, rdata}, 32'd0);
      end
      chk("one_gnt", {31'd0, a_gnt & b_gnt}, 32'd0);
      if (!ready) chk("gnt_not_ready", {30'd0, a_gnt, b_gnt}, 32'd0);
      if (a_gnt && a_req) begin
        if (a_we) model[a_addr] = a_din;
        else exp_q.push_back('{1'b0, model[a_addr]});
      end else if (b_gnt && b_req) begin
        if (b_we) model[b_addr] = b_din;
        else exp_q.push_back('{1'b1, model[b_addr]});
      end
    end
  end

  typedef struct {
    logic          ar, aw;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          br, bw;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          eag, ebg;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad, input logic br, input logic bw,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic eag, input logic ebg);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg;
    return v;
  endfunction

  task automatic clear_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
  endtask

  task automatic wait_ready(input string name);
    int edges;
    edges = 0;
    while (!ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk(name, edges, 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  vec_t vecs [20];

  initial begin
    // last grant is A when the table starts (A-only reads precede it)
    vecs[0]  = mk(1, 1, 4'd3,  16'h1234, 0, 0, 4'd0,  16'h0,    1, 0);
    vecs[1]  = mk(1, 0, 4'd3,  16'h0,    0, 0, 4'd0,  16'h0,    1, 0);
    vecs[2]  = mk(0, 0, 4'd0,  16'h0,    1, 1, 4'd5,  16'h00B5, 0, 1);
    vecs[3]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    1, 0);
    vecs[4]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[5]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    1, 0);
    vecs[6]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[7]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    1, 0);
    vecs[8]  = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[9]  = mk(0, 0, 4'd0,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[10] = mk(0, 0, 4'd0,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[11] = mk(0, 0, 4'd0,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[12] = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    1, 0);
    vecs[13] = mk(1, 0, 4'd3,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[14] = mk(1, 1, 4'd5,  16'hBEEF, 0, 0, 4'd0,  16'h0,    1, 0);
    vecs[15] = mk(0, 0, 4'd0,  16'h0,    1, 0, 4'd5,  16'h0,    0, 1);
    vecs[16] = mk(0, 0, 4'd0,  16'h0,    0, 0, 4'd0,  16'h0,    0, 0);
    vecs[17] = mk(1, 1, 4'd0,  16'hFFFF, 1, 1, 4'd15, 16'hAAAA, 1, 0);
    vecs[18] = mk(0, 0, 4'd0,  16'h0,    1, 1, 4'd15, 16'hAAAA, 0, 1);
    vecs[19] = mk(1, 0, 4'd15, 16'h0,    0, 0, 4'd0,  16'h0,    1, 0);

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    clear_inputs();
    nreset = 1'b0;
    b_req  = 1'b1;
    b_addr = 4'd7;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_ready_noinit", {31'd0, ready2}, 32'd1);
    chk("rst_gnt_noinit", {31'd0, b_gnt2}, 32'd0);

    // b_req is held through INIT; it must be granted the first ready cycle
    @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("noinit_gnt_b", {31'd0, b_gnt2}, 32'd1);
    wait_ready("init_len");
    @(negedge clk);
    chk("init_b_gnt", {31'd0, b_gnt}, 32'd1);
    @(posedge clk);
    #1;
    b_req = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      a_req  = 1'b1;
      a_addr = AW'(i);
      @(negedge clk);
      chk($sformatf("zero_rd_gnt%0d", i), {31'd0, a_gnt}, 32'd1);
      @(posedge clk);
      #1;
    end
    a_req = 1'b0;

    for (int i = 0; i < 20; i++) begin
      a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_din = vecs[i].ad;
      b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_din = vecs[i].bd;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), {30'd0, a_gnt, b_gnt}, {30'd0, vecs[i].eag, vecs[i].ebg});
      @(posedge clk);
      #1;
    end
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset lands while a granted A read is about to return data
    a_req  = 1'b1;
    a_addr = 4'd3;
    @(posedge clk);
    #1;
    a_req = 1'b0;
    chk("pre_rst_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("pre_rst_rdata", {16'd0, rdata}, 32'h1234);
    mon_en = 1'b0;
    exp_q.delete();
    nreset = 1'b0;
    #1;
    chk("midrst_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("midrst_rdata", {16'd0, rdata}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
    wait_ready("reinit_len");

    // Re-zeroed contents; after reset B holds the pointer so A wins the tie
    a_req = 1'b1; a_addr = 4'd3;
    b_req = 1'b1; b_addr = 4'd5;
    @(negedge clk);
    chk("reinit_tie", {30'd0, a_gnt, b_gnt}, 32'd2);
    @(posedge clk);
    #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("reinit_b", {30'd0, a_gnt, b_gnt}, 32'd1);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
